// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises N_REQ requesters onto one single-port memory, one
// transaction at a time, with round-robin or port-0-priority selection.
module mem_arbiter #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter bit PRIO0  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          we,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_w_en,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy
);

   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     cur_id, last_grant, win_id;
   logic                cur_we;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;
   logic                any_req;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign any_req = |req;

   // Rotating search starting just after the last winner; port 0 overrides
   // the rotation when PRIO0 is set.
   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      found  = 1'b0;
      idx    = '0;
      win_id = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
      if (PRIO0 && req[0])
         win_id = '0;
   end

   // AND-OR style select so undriven fields of losing ports never reach cur_*.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == win_id) begin
            sel_we    = we[i];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_id     <= '0;
         cur_we     <= 1'b0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         last_grant <= ID_W'(N_REQ - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            cur_id     <= win_id;
            cur_we     <= sel_we;
            cur_addr   <= sel_addr;
            cur_wdata  <= sel_wdata;
            last_grant <= win_id;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      rvalid    = '0;
      rdata     = '0;
      mem_w_en  = 1'b0;
      case (state)
         IDLE: begin
            if (any_req)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            gnt[cur_id] = 1'b1;
            mem_w_en    = cur_we;
            state_nxt   = cur_we ? IDLE : RESP;
         end
         RESP: begin
            rvalid[cur_id] = 1'b1;
            rdata          = mem_rdata;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_addr  = cur_addr;
   assign mem_wdata = cur_wdata;
   assign busy      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port (mmu: addr, w_en, data_w, data_r) between N_REQ requesters.
- Requesters are the core fetch/data path on port 0 and a debug/program loader or DMA on port 1+.
- Serialises one transaction at a time through a small FSM with round-robin or port-0-priority selection.
- Returns read data to the winning requester only.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- PRIO0, 0, 1 = port 0 always wins contention; 0 = round-robin.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-port request; held until its gnt bit is seen.
- we  in  N_REQ  per-port write enable; valid while req is high.
- addr  in  N_REQ*ADDR_W  flattened per-port address; port i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  flattened per-port write data.
- gnt  out  N_REQ  one-hot, one-cycle pulse: transaction is on the memory bus this cycle.
- rvalid  out  N_REQ  one-hot, one-cycle pulse: rdata is valid for that port.
- rdata  out  DATA_W  read data, shared by all ports.
- mem_addr  out  ADDR_W  to mmu addr.
- mem_w_en  out  1  to mmu w_en.
- mem_wdata  out  DATA_W  to mmu data_w.
- mem_rdata  in  DATA_W  from mmu data_r; valid one cycle after the address.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE: if any req is high, go to ISSUE.
  - ISSUE: go to RESP for a read, IDLE for a write.
  - RESP: go to IDLE.
- Arbitration is sampled only at a rising edge in IDLE.
  - The winner's index, we, addr and wdata are latched into cur_id, cur_we, cur_addr, cur_wdata.
  - Later changes on the requester's inputs are ignored.
- Selection:
  - PRIO0=1: port 0 wins if it is requesting; otherwise the round-robin rule applies to the rest.
  - PRIO0=0: search starts at last_grant+1 modulo N_REQ, and the first requesting port wins.
  - last_grant is updated to the winner on every grant.
- ISSUE cycle:
  - mem_addr = cur_addr, mem_wdata = cur_wdata, mem_w_en = cur_we.
  - gnt[cur_id] = 1.
  - The requester may drop or change req at the edge that ends ISSUE.
- RESP cycle:
  - rvalid[cur_id] = 1, rdata = mem_rdata.
  - mem_w_en = 0.
  - mem_addr holds cur_addr.
- Outside ISSUE:
  - mem_w_en = 0 at all times.
  - mem_addr/mem_wdata hold their last latched values; this is don't-care for the mmu.
- Latency, from the edge at which req is sampled in IDLE:
  - Read: gnt in the next cycle, rvalid the cycle after that.
  - Write: gnt in the next cycle, and the write commits at the edge ending ISSUE.
- Throughput:
  - One read per 3 cycles, one write per 2 cycles.
  - No pipelining of back-to-back transactions.
- A req still high at the edge ending ISSUE or RESP is not re-arbitrated. Only IDLE samples req, so a granted requester that drops req at its gnt edge is never double-granted.
- A requester that keeps req high after gnt is treated as a new request at the next IDLE edge.
- A port with req low never receives gnt or rvalid.
- gnt and rvalid are never asserted in the same cycle, and each is at most one-hot.
- Reset (rst high at an edge), from any state, including mid-ISSUE or mid-RESP:
  - Next state IDLE.
  - gnt=0, rvalid=0, mem_w_en=0, busy=0, rdata=0.
  - cur_* cleared to 0.
  - last_grant = N_REQ-1, so port 0 has first turn.
  - An in-flight read is abandoned with no rvalid.
  - A write whose ISSUE edge coincides with rst still reaches the mmu, because mem_w_en was high during that cycle.
- The x in `addr`/`wdata` of non-requesting ports must not propagate to mem_* outputs.

Test Plan:
- Single read:
  - Stimulus: after reset, port0 req=1, we=0, addr=0x0010; mmu returns 0xBEEF.
  - Required: gnt=01 in the following cycle with mem_addr=0x0010 and mem_w_en=0; then rvalid=01 with rdata=0xBEEF; busy high for exactly 2 cycles.
- Single write:
  - Stimulus: port1 req=1, we=1, addr=0x0200, wdata=0x1234.
  - Required: gnt=10 for one cycle with mem_w_en=1 and mem_wdata=0x1234; no rvalid; back in IDLE after 2 cycles.
- Contention, PRIO0=0:
  - Stimulus: both ports hold req continuously, all reads.
  - Required: gnt sequence 01, 10, 01, 10; each rvalid matches the preceding gnt port; 3 cycles per transaction.
- Contention, PRIO0=1:
  - Stimulus: both ports hold req for 4 transactions.
  - Required: port 1 gets no gnt until port 0 drops req; then port 1 is granted at the next IDLE.
- Input stability:
  - Stimulus: port0 changes addr from 0x0010 to 0x0099 during ISSUE.
  - Required: mem_addr stays 0x0010.
- Reset mid-read:
  - Stimulus: assert rst during the RESP cycle.
  - Required: no rvalid afterwards; all outputs 0; next simultaneous req from both ports grants port 0 first.
